memwb_skid_stage: RTL and testbench
===================================

# memwb_skid_stage

Parametrised MEM/WB pipeline stage with a valid/ready handshake and a two-entry skid buffer. It carries the write-back control field, the memory read data, the ALU result and the destination register from the MEM stage to the WB stage. It replaces the plain always-load pipeline register, so the stage can:

- absorb one beat of downstream stall without combinational ready paths;
- be flushed to a bubble;
- suppress register-file writes for invalid slots.

## Interface
- WB_W, 2, width of the write-back control field (bit 0 = RegWrite, bit 1 = MemtoReg)
- DATA_W, 32, width of rdata and ALU result
- REG_W, 5, width of destination register index

- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-low
- flush_i  in  1  synchronous flush; empties the stage
- valid_i  in  1  upstream beat valid
- ready_o  out  1  stage can accept a beat this cycle
- WB_i  in  WB_W  write-back control
- rdata_i  in  DATA_W  memory read data
- ALU_output_i  in  DATA_W  ALU result
- reg_dst_i  in  REG_W  destination register
- valid_o  out  1  output beat valid
- ready_i  in  1  downstream accepts output beat
- WB_o  out  WB_W  write-back control; forced 0 when valid_o=0
- rdata_o  out  DATA_W  memory read data
- ALU_output_o  out  DATA_W  ALU result
- reg_dst_o  out  REG_W  destination register
- count_o  out  2  occupancy, 0..2

## Operation
- Storage:
  - main register drives the outputs;
  - skid register holds one extra beat.
- Handshakes:
  - in_xfer = valid_i & ready_o;
  - out_xfer = valid_o & ready_i.
- FSM states: EMPTY (count 0), ONE (main valid), FULL (main and skid valid).
- Derived outputs, decoded from the state register only:
  - valid_o = (state != EMPTY);
  - ready_o = (state != FULL);
  - no combinational path from ready_i or valid_i to ready_o or valid_o.
- Transitions:
  - EMPTY: in_xfer -> ONE, main <= inputs; else stay.
  - ONE:
    - in_xfer & out_xfer -> ONE, main <= inputs;
    - in_xfer & !out_xfer -> FULL, skid <= inputs;
    - !in_xfer & out_xfer -> EMPTY;
    - otherwise stay, main holds.
  - FULL: out_xfer -> ONE, main <= skid; else hold. in_xfer cannot occur because ready_o=0.
- Priority: reset > flush > handshake.
- Flush:
  - next state EMPTY; any concurrent in_xfer beat is discarded;
  - data registers may keep stale values, but WB_o reads 0.
- WB_o gating: WB_o = stored WB & {WB_W{valid_o}}. An invalid slot never asserts RegWrite.
- rdata_o, ALU_output_o and reg_dst_o hold their last loaded value while invalid.
- Ordering: beats leave in acceptance order; no loss, no duplication.

## Timing
- Reset (rst_i=0 at a rising edge), after that edge:
  - state EMPTY, valid_o=0, count_o=0, ready_o=1, WB_o=0;
  - rdata_o, ALU_output_o, reg_dst_o = 0; skid contents = 0.
  - Reset mid-operation, including in FULL, discards both entries in the same way.
- Latency: a beat accepted at edge N is on the outputs with valid_o=1 after edge N, i.e. 1 cycle.
- Throughput: 1 beat/cycle while ready_i=1; count_o stays 1 in steady streaming.
- Stall absorption:
  - when ready_i drops, one further beat is absorbed (FULL), then ready_o=0 from the next cycle;
  - resuming drains the skid on the first out_xfer edge, and ready_o returns to 1 in the same cycle as state ONE.
- Flush in the same cycle as out_xfer: the downstream beat counts as consumed; state EMPTY after the edge.

## Test plan
- Reset:
  - stimulus: rst_i=0 for 2 cycles with valid_i=1, WB_i=2'b11, ALU_output_i=32'hDEAD;
  - response: valid_o=0, WB_o=0, ALU_output_o=0, count_o=0, ready_o=1 after release.
- Streaming:
  - stimulus: ready_i=1, four beats with ALU_output_i=1,2,3,4, reg_dst_i=5..8;
  - response: same values on consecutive cycles, each 1 cycle after acceptance; count_o=1; ready_o never drops.
- Backpressure:
  - stimulus: ready_i=0, offer beats A=10, B=20, C=30;
  - response: A on the outputs, B in skid, count_o=2, ready_o=0, C not accepted;
  - then set ready_i=1: outputs 10, 20, 30 on three consecutive cycles, no duplicates.
- Flush while FULL:
  - stimulus: assert flush_i with a concurrent valid_i beat 40;
  - response: next cycle valid_o=0, WB_o=0, count_o=0, ready_o=1; beat 40 never appears.
- Simultaneous in/out in ONE:
  - stimulus: hold valid_i=1, ready_i=1 with WB_i toggling 01/00;
  - response: count_o stays 1; WB_o follows one cycle late; WB_o=0 during any bubble.
- Reset mid-FULL:
  - stimulus: rst_i=0 for one edge while count_o=2;
  - response: count_o=0, valid_o=0, all data outputs 0, ready_o=1.

Source files
------------

// File: rtl/memwb_skid_stage.sv
// MEM/WB pipeline stage with a valid/ready handshake and a two-entry skid buffer.
// valid_o/ready_o decode the state register only, so there is no combinational ready path.
module memwb_skid_stage #(
    parameter int unsigned WB_W   = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [WB_W-1:0]   WB_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [DATA_W-1:0] ALU_output_i,
    input  logic [REG_W-1:0]  reg_dst_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [WB_W-1:0]   WB_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [DATA_W-1:0] ALU_output_o,
    output logic [REG_W-1:0]  reg_dst_o,
    output logic [1:0]        count_o
);

    localparam logic [1:0] StEmpty = 2'd0;
    localparam logic [1:0] StOne   = 2'd1;
    localparam logic [1:0] StFull  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [WB_W-1:0]   wb_q, wb_d, skid_wb_q, skid_wb_d;
    logic [DATA_W-1:0] rdata_q, rdata_d, skid_rdata_q, skid_rdata_d;
    logic [DATA_W-1:0] alu_q, alu_d, skid_alu_q, skid_alu_d;
    logic [REG_W-1:0]  reg_q, reg_d, skid_reg_q, skid_reg_d;
    logic              in_xfer, out_xfer;

    assign valid_o  = (state_q != StEmpty);
    assign ready_o  = (state_q != StFull);
    assign in_xfer  = valid_i & ready_o;
    assign out_xfer = valid_o & ready_i;

    always_comb begin
        state_d      = state_q;
        wb_d         = wb_q;
        rdata_d      = rdata_q;
        alu_d        = alu_q;
        reg_d        = reg_q;
        skid_wb_d    = skid_wb_q;
        skid_rdata_d = skid_rdata_q;
        skid_alu_d   = skid_alu_q;
        skid_reg_d   = skid_reg_q;
        if (flush_i) begin
            // Data may stay stale; the gated WB_o keeps the bubble harmless.
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (in_xfer) begin
                        state_d = StOne;
                        wb_d    = WB_i;
                        rdata_d = rdata_i;
                        alu_d   = ALU_output_i;
                        reg_d   = reg_dst_i;
                    end
                end
                StOne: begin
                    if (in_xfer && out_xfer) begin
                        wb_d    = WB_i;
                        rdata_d = rdata_i;
                        alu_d   = ALU_output_i;
                        reg_d   = reg_dst_i;
                    end else if (in_xfer) begin
                        state_d      = StFull;
                        skid_wb_d    = WB_i;
                        skid_rdata_d = rdata_i;
                        skid_alu_d   = ALU_output_i;
                        skid_reg_d   = reg_dst_i;
                    end else if (out_xfer) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (out_xfer) begin
                        state_d = StOne;
                        wb_d    = skid_wb_q;
                        rdata_d = skid_rdata_q;
                        alu_d   = skid_alu_q;
                        reg_d   = skid_reg_q;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= StEmpty;
            wb_q         <= '0;
            rdata_q      <= '0;
            alu_q        <= '0;
            reg_q        <= '0;
            skid_wb_q    <= '0;
            skid_rdata_q <= '0;
            skid_alu_q   <= '0;
            skid_reg_q   <= '0;
        end else begin
            state_q      <= state_d;
            wb_q         <= wb_d;
            rdata_q      <= rdata_d;
            alu_q        <= alu_d;
            reg_q        <= reg_d;
            skid_wb_q    <= skid_wb_d;
            skid_rdata_q <= skid_rdata_d;
            skid_alu_q   <= skid_alu_d;
            skid_reg_q   <= skid_reg_d;
        end
    end

    assign WB_o         = wb_q & {WB_W{valid_o}};
    assign rdata_o      = rdata_q;
    assign ALU_output_o = alu_q;
    assign reg_dst_o    = reg_q;
    assign count_o      = state_q;

endmodule

// File: tb/tb_memwb_skid_stage.sv
// Scoreboard bench for memwb_skid_stage: stimulus queues expected beats, a monitor pops them
// on every output transfer.
module tb_memwb_skid_stage;

    typedef struct packed {
        logic [1:0]  wb;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  rg;
    } beat_t;

    logic        clk_i = 1'b0;
    logic        rst_i, flush_i, valid_i, ready_i;
    logic        ready_o, valid_o;
    logic [1:0]  WB_i, WB_o, count_o;
    logic [31:0] rdata_i, ALU_output_i, rdata_o, ALU_output_o;
    logic [4:0]  reg_dst_i, reg_dst_o;

    beat_t q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    n_out   = 0;

    always #5 clk_i = ~clk_i;

    memwb_skid_stage #(.WB_W(2), .DATA_W(32), .REG_W(5)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .WB_i         (WB_i),
        .rdata_i      (rdata_i),
        .ALU_output_i (ALU_output_i),
        .reg_dst_i    (reg_dst_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .WB_o         (WB_o),
        .rdata_o      (rdata_o),
        .ALU_output_o (ALU_output_o),
        .reg_dst_o    (reg_dst_o),
        .count_o      (count_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: mid-cycle sampling, pops on each output transfer.
    always @(negedge clk_i) begin
        if (rst_i) begin
            if (!valid_o) check("wb_gated_when_invalid", {62'd0, WB_o}, 64'd0);
            if (valid_o && ready_i) begin
                n_out++;
                if (q.size() == 0) begin
                    check("unexpected_beat", {32'd0, ALU_output_o}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    beat_t e;
                    e = q.pop_front();
                    check("out_wb", {62'd0, WB_o}, {62'd0, e.wb});
                    check("out_rdata", {32'd0, rdata_o}, {32'd0, e.rd});
                    check("out_alu", {32'd0, ALU_output_o}, {32'd0, e.alu});
                    check("out_reg", {59'd0, reg_dst_o}, {59'd0, e.rg});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Offers a beat and returns #1 after the edge that accepted it.
    task automatic send(input logic [1:0] wb, input logic [31:0] alu, input logic [4:0] rg);
        beat_t b;
        bit    done = 0;
        b = '{wb: wb, rd: alu + 32'h100, alu: alu, rg: rg};
        valid_i      = 1'b1;
        WB_i         = wb;
        rdata_i      = b.rd;
        ALU_output_i = alu;
        reg_dst_i    = rg;
        for (int i = 0; i < 16 && !done; i++) begin
            @(negedge clk_i);
            if (ready_o) begin
                q.push_back(b);
                done = 1;
            end
            step();
        end
        if (!done) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b0; flush_i = 1'b0; valid_i = 1'b1; ready_i = 1'b0;
        WB_i = 2'b11; rdata_i = 32'h55; ALU_output_i = 32'hDEAD; reg_dst_i = 5'd3;
        step();
        step();
        check("rst_valid", {63'd0, valid_o}, 64'd0);
        check("rst_wb", {62'd0, WB_o}, 64'd0);
        check("rst_alu", {32'd0, ALU_output_o}, 64'd0);
        check("rst_count", {62'd0, count_o}, 64'd0);
        check("rst_ready", {63'd0, ready_o}, 64'd1);
        valid_i = 1'b0;
        rst_i   = 1'b1;
        step();
        check("rel_valid", {63'd0, valid_o}, 64'd0);
        check("rel_ready", {63'd0, ready_o}, 64'd1);

        // Streaming
        ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send(2'b01, 32'(k + 1), 5'(k + 5));
            check("stream_count", {62'd0, count_o}, 64'd1);
            check("stream_ready", {63'd0, ready_o}, 64'd1);
        end
        idle(3);

        // Backpressure
        ready_i = 1'b0;
        send(2'b01, 32'd10, 5'd10);
        check("bp_count_a", {62'd0, count_o}, 64'd1);
        send(2'b11, 32'd20, 5'd11);
        check("bp_count_b", {62'd0, count_o}, 64'd2);
        check("bp_ready_full", {63'd0, ready_o}, 64'd0);
        check("bp_main_a", {32'd0, ALU_output_o}, 64'd10);
        valid_i = 1'b1; ALU_output_i = 32'd30; reg_dst_i = 5'd12; WB_i = 2'b01;
        @(negedge clk_i);
        check("bp_c_refused", {63'd0, ready_o}, 64'd0);
        step();
        check("bp_count_hold", {62'd0, count_o}, 64'd2);
        check("bp_main_hold", {32'd0, ALU_output_o}, 64'd10);
        ready_i = 1'b1;
        send(2'b01, 32'd30, 5'd12);
        idle(4);
        check("bp_drained_count", {62'd0, count_o}, 64'd0);

        // Flush while FULL with a concurrent beat
        ready_i = 1'b0;
        send(2'b01, 32'd50, 5'd13);
        send(2'b01, 32'd60, 5'd14);
        check("fl_count_full", {62'd0, count_o}, 64'd2);
        valid_i = 1'b1; ALU_output_i = 32'd40; reg_dst_i = 5'd15; WB_i = 2'b11;
        flush_i = 1'b1;
        step();
        q.delete();
        flush_i = 1'b0;
        valid_i = 1'b0;
        check("fl_valid", {63'd0, valid_o}, 64'd0);
        check("fl_wb", {62'd0, WB_o}, 64'd0);
        check("fl_count", {62'd0, count_o}, 64'd0);
        check("fl_ready", {63'd0, ready_o}, 64'd1);
        ready_i = 1'b1;
        idle(3);

        // Simultaneous in/out in ONE with a bubble
        for (int k = 0; k < 4; k++) begin
            send((k % 2 == 0) ? 2'b01 : 2'b00, 32'(70 + k), 5'(20 + k));
            check("sim_count", {62'd0, count_o}, 64'd1);
        end
        idle(1);
        check("sim_bubble_count", {62'd0, count_o}, 64'd0);
        send(2'b01, 32'd80, 5'd24);
        send(2'b00, 32'd81, 5'd25);
        idle(3);

        // Reset while FULL
        ready_i = 1'b0;
        send(2'b11, 32'd90, 5'd26);
        send(2'b11, 32'd91, 5'd27);
        check("rf_count_full", {62'd0, count_o}, 64'd2);
        rst_i = 1'b0;
        step();
        q.delete();
        rst_i = 1'b1;
        check("rf_count", {62'd0, count_o}, 64'd0);
        check("rf_valid", {63'd0, valid_o}, 64'd0);
        check("rf_wb", {62'd0, WB_o}, 64'd0);
        check("rf_rdata", {32'd0, rdata_o}, 64'd0);
        check("rf_alu", {32'd0, ALU_output_o}, 64'd0);
        check("rf_reg", {59'd0, reg_dst_o}, 64'd0);
        check("rf_ready", {63'd0, ready_o}, 64'd1);
        ready_i = 1'b1;
        idle(3);

        check("total_outputs", 64'(n_out), 64'd13);
        check("queue_empty", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
